masked_vector_rf: RTL and testbench

// - Per-lane write-masked vector register file for the GPGPU datapath; generalised successor of the fixed 8x32b masked RF.
// - NUM_LANES lanes of LANE_W bits, DEPTH entries, one masked write port, two independent registered read ports (A/B).
// - Built-in clear sequencer zeroes every entry after reset or on request; BRAM-inferable array (no array reset).

---
 rtl/masked_vector_rf.sv | 155 +++++++++++++++
 tb/tb_masked_vector_rf.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/masked_vector_rf.sv
// Per-lane write-masked vector register file: one masked write port, two registered read ports,
// built-in zero-fill sweep. Define RF_BYPASS_EN for lane-granular write-first read-during-write.

module masked_vector_rf_lane #(
    parameter int LANE_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [LANE_W-1:0] wdata_i,
    input  logic              re_a_i,
    input  logic              ok_a_i,
    input  logic              fwd_a_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [LANE_W-1:0] rdata_a_o,
    input  logic              re_b_i,
    input  logic              ok_b_i,
    input  logic              fwd_b_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [LANE_W-1:0] rdata_b_o
);
    logic [LANE_W-1:0] mem_q [DEPTH];
    logic [LANE_W-1:0] rdata_a_q, rdata_b_q;

    // Storage carries no reset so it can map onto block RAM; the sweep zeroes it instead.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (re_a_i) rdata_a_q <= !ok_a_i ? '0 : (fwd_a_i ? wdata_i : mem_q[raddr_a_i]);
            if (re_b_i) rdata_b_q <= !ok_b_i ? '0 : (fwd_b_i ? wdata_i : mem_q[raddr_b_i]);
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;
endmodule

module masked_vector_rf #(
    parameter int NUM_LANES = 8,
    parameter int LANE_W    = 32,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    output logic                        ready_o,
    input  logic                        wr_en_i,
    input  logic [NUM_LANES-1:0]        wr_mask_i,
    input  logic [ADDR_W-1:0]           wr_addr_i,
    input  logic [NUM_LANES*LANE_W-1:0] wr_data_i,
    input  logic                        rd_en_a_i,
    input  logic [ADDR_W-1:0]           rd_addr_a_i,
    output logic [NUM_LANES*LANE_W-1:0] rd_data_a_o,
    output logic                        rd_valid_a_o,
    input  logic                        rd_en_b_i,
    input  logic [ADDR_W-1:0]           rd_addr_b_i,
    output logic [NUM_LANES*LANE_W-1:0] rd_data_b_o,
    output logic                        rd_valid_b_o
);
    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_IDLE  = 1'b1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic              state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              vld_a_q, vld_b_q;
    logic              clearing, wr_ok, wr_go, ok_a, ok_b, acc_a, acc_b;
    logic [ADDR_W-1:0] mem_addr;

    assign clearing = (state_q == ST_CLEAR);
    assign ready_o  = (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (clearing) begin
            if (clear_i) begin
                clr_idx_d = '0;
            end else if (clr_idx_q == ADDR_W'(DEPTH-1)) begin
                state_d   = ST_IDLE;
                clr_idx_d = '0;
            end else begin
                clr_idx_d = clr_idx_q + 1'b1;
            end
        end else if (clear_i) begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            vld_a_q   <= 1'b0;
            vld_b_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            vld_a_q   <= acc_a;
            vld_b_q   <= acc_b;
        end
    end

    // Out-of-range addresses only occur for non-power-of-two DEPTH.
    assign wr_ok    = ({1'b0, wr_addr_i} < DEPTH_X);
    assign ok_a     = ({1'b0, rd_addr_a_i} < DEPTH_X);
    assign ok_b     = ({1'b0, rd_addr_b_i} < DEPTH_X);
    assign wr_go    = ready_o & wr_en_i & ~clear_i & wr_ok;
    assign acc_a    = ready_o & rd_en_a_i;
    assign acc_b    = ready_o & rd_en_b_i;
    assign mem_addr = clearing ? clr_idx_q : wr_addr_i;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic we, fwd_a, fwd_b;
        assign we = clearing | (wr_go & wr_mask_i[i]);
`ifdef RF_BYPASS_EN
        assign fwd_a = wr_go & wr_mask_i[i] & (wr_addr_i == rd_addr_a_i);
        assign fwd_b = wr_go & wr_mask_i[i] & (wr_addr_i == rd_addr_b_i);
`else
        assign fwd_a = 1'b0;
        assign fwd_b = 1'b0;
`endif
        masked_vector_rf_lane #(.LANE_W(LANE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lane (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .we_i      (we),
            .waddr_i   (mem_addr),
            .wdata_i   (clearing ? '0 : wr_data_i[i*LANE_W +: LANE_W]),
            .re_a_i    (acc_a),
            .ok_a_i    (ok_a),
            .fwd_a_i   (fwd_a),
            .raddr_a_i (rd_addr_a_i),
            .rdata_a_o (rd_data_a_o[i*LANE_W +: LANE_W]),
            .re_b_i    (acc_b),
            .ok_b_i    (ok_b),
            .fwd_b_i   (fwd_b),
            .raddr_b_i (rd_addr_b_i),
            .rdata_b_o (rd_data_b_o[i*LANE_W +: LANE_W])
        );
    end

    assign rd_valid_a_o = vld_a_q;
    assign rd_valid_b_o = vld_b_q;
endmodule

// File: tb/tb_masked_vector_rf.sv
// Directed bench for masked_vector_rf: DEPTH=8 instance for the main function, DEPTH=6 for range/reset cases.

module tb_masked_vector_rf;
    localparam int W = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, clear, ready, wr_en, rd_en_a, rd_en_b, rd_valid_a, rd_valid_b;
    logic [7:0]   wr_mask;
    logic [2:0]   wr_addr, rd_addr_a, rd_addr_b;
    logic [W-1:0] wr_data, rd_data_a, rd_data_b;

    logic         rst6, clear6, ready6, wr_en6, rd_en_a6, rd_en_b6, rd_valid_a6, rd_valid_b6;
    logic [7:0]   wr_mask6;
    logic [2:0]   wr_addr6, rd_addr_a6, rd_addr_b6;
    logic [W-1:0] wr_data6, rd_data_a6, rd_data_b6;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt;
    logic [W-1:0] exp_v;

    masked_vector_rf #(.NUM_LANES(8), .LANE_W(32), .DEPTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .ready_o(ready),
        .wr_en_i(wr_en), .wr_mask_i(wr_mask), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_a_i(rd_en_a), .rd_addr_a_i(rd_addr_a), .rd_data_a_o(rd_data_a), .rd_valid_a_o(rd_valid_a),
        .rd_en_b_i(rd_en_b), .rd_addr_b_i(rd_addr_b), .rd_data_b_o(rd_data_b), .rd_valid_b_o(rd_valid_b)
    );

    masked_vector_rf #(.NUM_LANES(8), .LANE_W(32), .DEPTH(6)) dut6 (
        .clk_i(clk), .rst_i(rst6), .clear_i(clear6), .ready_o(ready6),
        .wr_en_i(wr_en6), .wr_mask_i(wr_mask6), .wr_addr_i(wr_addr6), .wr_data_i(wr_data6),
        .rd_en_a_i(rd_en_a6), .rd_addr_a_i(rd_addr_a6), .rd_data_a_o(rd_data_a6), .rd_valid_a_o(rd_valid_a6),
        .rd_en_b_i(rd_en_b6), .rd_addr_b_i(rd_addr_b6), .rd_data_b_o(rd_data_b6), .rd_valid_b_o(rd_valid_b6)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] m, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd_a(input logic [2:0] a);
        rd_en_a = 1'b1; rd_addr_a = a;
        step();
        rd_en_a = 1'b0;
    endtask

    initial begin
        rst = 0; clear = 0; wr_en = 0; wr_mask = 0; wr_addr = 0; wr_data = 0;
        rd_en_a = 0; rd_addr_a = 0; rd_en_b = 0; rd_addr_b = 0;
        rst6 = 0; clear6 = 0; wr_en6 = 0; wr_mask6 = 0; wr_addr6 = 0; wr_data6 = 0;
        rd_en_a6 = 0; rd_addr_a6 = 0; rd_en_b6 = 0; rd_addr_b6 = 0;

        repeat (2) step();
        chk("rst_ready", W'(ready), W'(0));
        chk("rst_vld_a", W'(rd_valid_a), W'(0));
        chk("rst_data_a", rd_data_a, '0);
        chk("rst_data_b", rd_data_b, '0);

        rst = 1; rst6 = 1;
        cnt = 0;
        while (!ready && cnt < 20) begin step(); cnt++; end
        chk("init_clr_len", W'(cnt), W'(8));

        for (int e = 0; e < 8; e++) begin
            rd_a(3'(e));
            chk($sformatf("init_rd%0d", e), rd_data_a, '0);
            chk($sformatf("init_vld%0d", e), W'(rd_valid_a), W'(1));
        end
        step();
        chk("vld_pulse", W'(rd_valid_a), W'(0));

        // Masked writes to entry 3
        wr(3'd3, 8'hFF, {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0});
        wr(3'd3, 8'h0F, {8{32'h5555_5555}});
        wr(3'd3, 8'h00, {8{32'hFFFF_FFFF}});
        rd_a(3'd3);
        chk("mask_e3", rd_data_a, {32'hA7, 32'hA6, 32'hA5, 32'hA4, {4{32'h5555_5555}}});

        // Read-during-write on entry 2
        wr_en = 1; wr_addr = 3'd2; wr_mask = 8'h01; wr_data = {8{32'hDEAD_BEEF}};
        rd_en_a = 1; rd_addr_a = 3'd2;
        step();
        wr_en = 0; rd_en_a = 0;
`ifdef RF_BYPASS_EN
        exp_v = {{7{32'h0}}, 32'hDEAD_BEEF};
`else
        exp_v = '0;
`endif
        chk("rdw_e2", rd_data_a, exp_v);
        rd_a(3'd2);
        chk("after_rdw_e2", rd_data_a, {{7{32'h0}}, 32'hDEAD_BEEF});

        // Dual-port and back-to-back reads
        wr(3'd1, 8'hFF, {8{32'h1111_1111}});
        wr(3'd5, 8'hF0, {8{32'h5A5A_5A5A}});
        rd_en_a = 1; rd_addr_a = 3'd1; rd_en_b = 1; rd_addr_b = 3'd5;
        step();
        chk("dual_a", rd_data_a, {8{32'h1111_1111}});
        chk("dual_b", rd_data_b, {{4{32'h5A5A_5A5A}}, {4{32'h0}}});
        chk("dual_vld", W'({rd_valid_a, rd_valid_b}), W'(2'b11));
        rd_addr_a = 3'd3; rd_addr_b = 3'd1;
        step();
        chk("b2b_a", rd_data_a, {32'hA7, 32'hA6, 32'hA5, 32'hA4, {4{32'h5555_5555}}});
        chk("b2b_b", rd_data_b, {8{32'h1111_1111}});
        chk("b2b_vld", W'({rd_valid_a, rd_valid_b}), W'(2'b11));
        rd_en_a = 0; rd_en_b = 0;
        step();
        chk("b2b_vld_end", W'({rd_valid_a, rd_valid_b}), W'(2'b00));

        // Clear pulse with a write to entry 4 in the same cycle; traffic during sweep ignored
        clear = 1; wr_en = 1; wr_addr = 3'd4; wr_mask = 8'hFF; wr_data = {8{32'hCAFE_F00D}};
        step();
        clear = 0; wr_addr = 3'd1; rd_en_a = 1; rd_addr_a = 3'd1;
        cnt = 0;
        while (!ready && cnt < 20) begin
            cnt++;
            if (rd_valid_a) chk("clr_vld_a", W'(rd_valid_a), W'(0));
            step();
        end
        wr_en = 0; rd_en_a = 0;
        chk("clr_len", W'(cnt), W'(8));
        chk("clr_hold_vld", W'(rd_valid_a), W'(0));
        chk("clr_hold_data", rd_data_a, {32'hA7, 32'hA6, 32'hA5, 32'hA4, {4{32'h5555_5555}}});
        for (int e = 0; e < 8; e++) begin
            rd_a(3'(e));
            chk($sformatf("post_clr_rd%0d", e), rd_data_a, '0);
        end

        // DEPTH=6: out-of-range address handling
        wr_en6 = 1; wr_addr6 = 3'd7; wr_mask6 = 8'hFF; wr_data6 = {8{32'h7777_7777}};
        step();
        wr_addr6 = 3'd5; wr_data6 = {8{32'h1234_5678}};
        step();
        wr_en6 = 0;
        rd_en_a6 = 1; rd_addr_a6 = 3'd7;
        step();
        chk("d6_rd7", rd_data_a6, '0);
        chk("d6_rd7_vld", W'(rd_valid_a6), W'(1));
        for (int e = 0; e < 5; e++) begin
            rd_addr_a6 = 3'(e);
            step();
            chk($sformatf("d6_alias%0d", e), rd_data_a6, '0);
        end
        rd_addr_a6 = 3'd5;
        step();
        rd_en_a6 = 0;
        chk("d6_rd5", rd_data_a6, {8{32'h1234_5678}});

        // DEPTH=6: reset in the middle of a sweep
        clear6 = 1;
        step();
        clear6 = 0;
        step(); step();
        #2 rst6 = 0;
        #1;
        chk("d6_midrst_ready", W'(ready6), W'(0));
        chk("d6_midrst_data", rd_data_a6, '0);
        chk("d6_midrst_vld", W'(rd_valid_a6), W'(0));
        step();
        rst6 = 1;
        cnt = 0;
        while (!ready6 && cnt < 20) begin step(); cnt++; end
        chk("d6_restart_len", W'(cnt), W'(6));
        rd_en_a6 = 1; rd_addr_a6 = 3'd5;
        step();
        rd_en_a6 = 0;
        chk("d6_rd5_cleared", rd_data_a6, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
